// File: rtl/uart_rx.sv
// UART receiver with 16x oversampling, 7/8 data bits, optional odd/even parity and programmable stop length.
// Optional two-flop input synchronizer on rx is enabled by defining UART_RX_SYNC_EN.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_tick,
    input  logic       rx,
    input  logic [3:0] databits,
    input  logic [5:0] stopbits,
    input  logic [1:0] paritybit,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       parity_err,
    output logic       frame_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state;
    logic [5:0] s;
    logic [2:0] n;
    logic [7:0] shift;
    logic       perr;
    logic       rx_s;
    logic [7:0] word;
    logic [2:0] last_n;
    logic       parity_on;
    logic       exp_par;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], rx};
        end
    end

    assign rx_s = sync[1];
`else
    assign rx_s = rx;
`endif

    // In 7-bit mode the word ends up one place short of the shift register's LSB.
    always_comb begin
        word      = (databits == 4'd7) ? {1'b0, shift[7:1]} : shift;
        last_n    = (databits == 4'd7) ? 3'd6 : 3'd7;
        parity_on = (paritybit == 2'd1) || (paritybit == 2'd2);
        exp_par   = (paritybit == 2'd1) ? ~^word : ^word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            s            <= 6'd0;
            n            <= 3'd0;
            shift        <= 8'd0;
            perr         <= 1'b0;
            dout         <= 8'd0;
            rx_done_tick <= 1'b0;
            parity_err   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            rx_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        s     <= 6'd0;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s == 6'd7) begin
                            if (!rx_s) begin
                                state <= DATA;
                                s     <= 6'd0;
                                n     <= 3'd0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s == 6'd15) begin
                            s     <= 6'd0;
                            shift <= {rx_s, shift[7:1]};
                            if (n == last_n) begin
                                state <= PARITY;
                            end else begin
                                n <= n + 3'd1;
                            end
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                // With parity disabled this state passes straight through without consuming a tick.
                PARITY: begin
                    if (!parity_on) begin
                        perr  <= 1'b0;
                        s     <= 6'd0;
                        state <= STOP;
                    end else if (s_tick) begin
                        if (s == 6'd15) begin
                            perr  <= (rx_s != exp_par);
                            s     <= 6'd0;
                            state <= STOP;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                STOP: begin
                    if (s_tick) begin
                        if (s == stopbits - 6'd1) begin
                            rx_done_tick <= 1'b1;
                            dout         <= word;
                            frame_err    <= ~rx_s;
                            parity_err   <= perr;
                            state        <= IDLE;
                        end else begin
                            s <= s + 6'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
